core_data_arbiter: RTL and testbench
====================================

// Module: core_data_arbiter
// PURPOSE
//  Two-master arbiter for the single data-memory port (req/gnt/rvalid protocol).
//  Master 0 is the core MEM stage; master 1 is the debug/DMA loader.
//  Selects one master per cycle, holds the selection while a request waits for gnt,
//  and tracks outstanding reads so each in-order rvalid is routed to its issuer.
// PARAMETERS
//  ADDR_WIDTH   16  data-memory address width (matches MEM_ADDR_DATA_WIDTH)
//  DATA_WIDTH   32  data word width
//  BE_WIDTH     4   byte-enable width (MEM_TRANSFER_WIDTH)
//  RR_MODE      1   1 = round-robin; 0 = fixed priority, master 0 wins
//  MAX_OUTST    2   maximum outstanding reads (owner FIFO depth), >=1
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active-high
//  mN_req_i       in   1           master N request (N=0,1)
//  mN_wr_i        in   1           master N write (1) / read (0)
//  mN_addr_i      in   ADDR_WIDTH  master N address
//  mN_wdata_i     in   DATA_WIDTH  master N write data
//  mN_be_i        in   BE_WIDTH    master N byte enables
//  mN_gnt_o       out  1           master N request accepted this cycle
//  mN_rvalid_o    out  1           master N read data valid
//  mN_rdata_o     out  DATA_WIDTH  read data (data_rdata_i broadcast)
//  data_req_o     out  1           memory request
//  data_wr_o      out  1           memory write
//  data_addr_o    out  ADDR_WIDTH  memory address
//  data_wdata_o   out  DATA_WIDTH  memory write data
//  data_be_o      out  BE_WIDTH    memory byte enables
//  data_gnt_i     in   1           memory accepted request
//  data_rvalid_i  in   1           memory read data valid (in order)
//  data_rdata_i   in   DATA_WIDTH  memory read data
//  rsp_err_o      out  1           sticky: rvalid received with no read outstanding
// BEHAVIOUR
//  - Reset: state ARB, last_grant=1 (master 0 wins first tie), owner FIFO empty,
//    rsp_err_o=0. All gnt/rvalid/req outputs are 0 while rst is high.
//  - Reads issued before reset are discarded; a later rvalid sets rsp_err_o.
//  - Path latency: request, address and gnt paths are combinational (zero latency).
//    mN_gnt_o = data_gnt_i & data_req_o & (sel==N).
//  - FSM states:
//    - ARB: sel chosen from current requests.
//      - Only one master requesting: sel = that master.
//      - Both requesting: RR_MODE=1 -> the master != last_grant; RR_MODE=0 -> master 0.
//      - Requested but not granted -> HOLD_N with sel frozen.
//    - HOLD_N: sel=N regardless of the other master.
//      - Leave to ARB on a granted transfer, or if mN_req_i drops (abandoned, no error).
//  - last_grant updates only on an accepted transfer (data_req_o & data_gnt_i).
//  - data_wr_o/addr/wdata/be are muxed from sel. When data_req_o=0 these outputs are 0.
//  - Owner FIFO (MAX_OUTST entries, 1 bit each):
//    - Push sel on an accepted read; pop on data_rvalid_i.
//    - mN_rvalid_o = data_rvalid_i & FIFO non-empty & head==N.
//  - Full: when count==MAX_OUTST, read requests are masked (data_req_o=0, no gnt),
//    even if a pop occurs the same cycle. Writes still pass while the FIFO is full.
//  - Simultaneous push and pop when not full: count unchanged, ordering preserved.
//  - rvalid with the FIFO empty: no mN_rvalid_o; rsp_err_o set until reset.
//  - Writes produce no rvalid and are never pushed into the FIFO.
//  - Counter width: clog2(MAX_OUTST+1). FIFO pointers wrap modulo MAX_OUTST.
// TESTING
//  1. Only m0 reads 0x0010, gnt=1 same cycle -> m0_gnt_o=1, data_addr_o=0x0010.
//     rvalid 2 cycles later with 0xDEADBEEF -> m0_rvalid_o=1, m1_rvalid_o=0.
//  2. RR_MODE=1, both request continuously, gnt always 1 -> grants alternate m0,m1,m0,m1.
//     RR_MODE=0 -> m0 every cycle.
//  3. m1 requests, gnt=0 for 3 cycles, then m0 also requests -> sel stays m1 (HOLD_1).
//     gnt=1 -> m1_gnt_o=1; m0 is granted next cycle.
//  4. MAX_OUTST=2: two granted reads (m0 then m1), no rvalid -> a third read is masked
//     (data_req_o=0) while a write passes. Two rvalids -> m0_rvalid_o then m1_rvalid_o.
//  5. data_rvalid_i pulse with the FIFO empty -> no master rvalid, rsp_err_o=1 until rst.
//  6. rst asserted with 1 read outstanding -> outputs 0 next cycle, count=0.
//     The stale rvalid then sets rsp_err_o.

Source files
------------

// File: rtl/core_data_arbiter.sv
// Two-master arbiter for the data-memory port (req/gnt/rvalid protocol).
// Holds the selected master until it is granted, and routes in-order read responses back to their issuers.
module core_data_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int RR_MODE    = 1,
    parameter int MAX_OUTST  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic                  m0_wr_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [BE_WIDTH-1:0]   m0_be_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_wr_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [BE_WIDTH-1:0]   m1_be_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  data_req_o,
    output logic                  data_wr_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output logic                  rsp_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {ARB, HOLD_0, HOLD_1} state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTST-1:0] owner_q;

    logic sel, full, empty, elig0, elig1, accept, push, pop, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    // A read cannot be offered while the owner FIFO is full; writes always can.
    assign elig0 = m0_req_i & (m0_wr_i | ~full);
    assign elig1 = m1_req_i & (m1_wr_i | ~full);

    always_comb begin
        sel        = 1'b0;
        state_d    = state_q;
        data_req_o = 1'b0;
        accept     = 1'b0;
        case (state_q)
            HOLD_0: sel = 1'b0;
            HOLD_1: sel = 1'b1;
            default: begin
                if (elig0 & elig1) sel = (RR_MODE != 0) ? ~last_grant_q : 1'b0;
                else               sel = elig1;
            end
        endcase
        data_req_o = (sel ? elig1 : elig0) & ~rst;
        accept     = data_req_o & data_gnt_i;
        case (state_q)
            HOLD_0: if (~m0_req_i | accept) state_d = ARB;
            HOLD_1: if (~m1_req_i | accept) state_d = ARB;
            default: if (data_req_o & ~data_gnt_i) state_d = sel ? HOLD_1 : HOLD_0;
        endcase
    end

    assign data_wr_o    = data_req_o & (sel ? m1_wr_i : m0_wr_i);
    assign data_addr_o  = data_req_o ? (sel ? m1_addr_i  : m0_addr_i)  : '0;
    assign data_wdata_o = data_req_o ? (sel ? m1_wdata_i : m0_wdata_i) : '0;
    assign data_be_o    = data_req_o ? (sel ? m1_be_i    : m0_be_i)    : '0;
    assign m0_gnt_o     = accept & ~sel;
    assign m1_gnt_o     = accept & sel;

    assign push = accept & ~data_wr_o;
    assign pop  = data_rvalid_i & ~empty & ~rst;
    assign head = owner_q[rd_ptr_q];

    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_rdata_o  = data_rdata_i;
    assign m1_rdata_o  = data_rdata_i;
    assign rsp_err_o   = rsp_err_q;

    always_comb begin
        last_grant_d = accept ? sel : last_grant_q;
        rsp_err_d    = rsp_err_q | (data_rvalid_i & empty);
        cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) owner_q[wr_ptr_q] <= sel;
    end

endmodule

// File: tb/tb_core_data_arbiter.sv
// Directed bench for core_data_arbiter: a scoreboard queue of expected grants and read responses,
// plus a fixed-priority instance sharing the same stimulus.
module tb_core_data_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        data_req_o, data_wr_o, rsp_err_o;
    logic [15:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_be_o;

    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_req, b_wr, b_err;
    logic [15:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        kind;   // 0 = grant, 1 = read response
        logic [1:0]  who;    // one-hot {m1, m0}
        logic [31:0] val;    // address for a grant, data for a response
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    core_data_arbiter #(.RR_MODE(1), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata), .rsp_err_o(rsp_err_o)
    );

    core_data_arbiter #(.RR_MODE(0), .MAX_OUTST(2)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
        .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
        .data_req_o(b_req), .data_wr_o(b_wr), .data_addr_o(b_addr),
        .data_wdata_o(b_wdata), .data_be_o(b_be),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata), .rsp_err_o(b_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input logic kind, input logic who, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.who  = who ? 2'b10 : 2'b01;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus, applied just after the rising edge.
    task automatic step(input logic rs,
                        input logic r0, input logic w0, input logic [15:0] a0,
                        input logic r1, input logic w1, input logic [15:0] a1,
                        input logic g, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst = rs;
        m0_req = r0; m0_wr = w0; m0_addr = a0;
        m1_req = r1; m1_wr = w1; m1_addr = a1;
        gnt = g; rvalid = rv; rdata = rd;
        #1;
    endtask

    task automatic idle(input logic rs);
        step(rs, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 32'h0);
    endtask

    // Monitor: every grant or response the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        if (m0_gnt_o | m1_gnt_o) begin
            if (exp_q.size() == 0 || exp_q[0].kind != 1'b0) begin
                total++; bad++;
                $display("FAIL unexpected_gnt actual=%b%b expected=none", m1_gnt_o, m0_gnt_o);
            end else begin
                e = exp_q.pop_front();
                check("gnt_who", {30'b0, m1_gnt_o, m0_gnt_o}, {30'b0, e.who});
                check("gnt_addr", {16'b0, data_addr_o}, e.val);
            end
        end
        if (m0_rvalid_o | m1_rvalid_o) begin
            if (exp_q.size() == 0 || exp_q[0].kind != 1'b1) begin
                total++; bad++;
                $display("FAIL unexpected_rvalid actual=%b%b expected=none", m1_rvalid_o, m0_rvalid_o);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_who", {30'b0, m1_rvalid_o, m0_rvalid_o}, {30'b0, e.who});
                check("rvalid_data", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, e.val);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m1_req = 0; m1_wr = 0; m1_addr = 0;
        m0_wdata = 32'hA0A0A0A0; m1_wdata = 32'hB1B1B1B1;
        m0_be = 4'h3; m1_be = 4'hC;
        gnt = 0; rvalid = 0; rdata = 0;

        // Reset: requests and gnt present, every output must stay quiet.
        step(1, 1, 0, 16'h0010, 1, 1, 16'h0020, 1, 0, 32'h5A5A5A5A);
        check("rst_req", {31'b0, data_req_o}, 0);
        check("rst_gnt", {30'b0, m1_gnt_o, m0_gnt_o}, 0);
        check("rst_addr", {16'b0, data_addr_o}, 0);
        check("rst_wdata", data_wdata_o, 0);
        check("rst_be_wr", {27'b0, data_be_o, data_wr_o}, 0);
        check("rst_fp_bus", {5'b0, b_req, b_m0_gnt, b_m1_gnt, b_wr, b_addr, b_be, b_m0_rvalid, b_m1_rvalid, b_err}, 0);
        check("rst_fp_wdata", b_wdata, 0);
        check("rst_fp_rdata", b_m0_rdata ^ b_m1_rdata ^ 32'h5A5A5A5A, 32'h5A5A5A5A);
        idle(1);
        idle(0);
        check("rst_err", {31'b0, rsp_err_o}, 0);

        // 1: single m0 read, response two cycles after the grant.
        step(0, 1, 0, 16'h0010, 0, 0, 16'h0, 1, 0, 32'h0);
        expect_ev(0, 0, 32'h0010);
        check("t1_addr", {16'b0, data_addr_o}, 32'h0010);
        check("t1_req", {31'b0, data_req_o}, 1);
        idle(0);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 32'hDEADBEEF);
        expect_ev(1, 0, 32'hDEADBEEF);
        check("t1_m1_rvalid", {31'b0, m1_rvalid_o}, 0);
        check("t1_fp_rvalid", {30'b0, b_m1_rvalid, b_m0_rvalid}, 2'b01);

        // 2: both write continuously. Last grant was m0, so round-robin starts with m1.
        for (int i = 0; i < 4; i++) begin
            logic who;
            who = (i % 2 == 0);
            step(0, 1, 1, 16'h0100, 1, 1, 16'h0200, 1, 0, 32'h0);
            expect_ev(0, who, who ? 32'h0200 : 32'h0100);
            check("t2_wr", {31'b0, data_wr_o}, 1);
            check("t2_wdata", data_wdata_o, who ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
            check("t2_be", {28'b0, data_be_o}, who ? 32'hC : 32'h3);
            check("t2_fp_gnt", {30'b0, b_m1_gnt, b_m0_gnt}, 2'b01);
        end
        idle(0);

        // 3: m1 stalls without gnt, then m0 joins; selection must stay on m1.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0, 1, 0, 16'h0300, 0, 0, 32'h0);
            check("t3_req", {31'b0, data_req_o}, 1);
            check("t3_addr", {16'b0, data_addr_o}, 32'h0300);
        end
        step(0, 1, 0, 16'h0040, 1, 0, 16'h0300, 0, 0, 32'h0);
        check("t3_hold_addr", {16'b0, data_addr_o}, 32'h0300);
        step(0, 1, 0, 16'h0040, 1, 0, 16'h0300, 1, 0, 32'h0);
        expect_ev(0, 1, 32'h0300);
        step(0, 1, 0, 16'h0040, 0, 0, 16'h0, 1, 0, 32'h0);
        expect_ev(0, 0, 32'h0040);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 32'h11111111);
        expect_ev(1, 1, 32'h11111111);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 32'h22222222);
        expect_ev(1, 0, 32'h22222222);
        idle(0);

        // 4: fill the owner FIFO, mask reads, let a write through, then push+pop together.
        step(0, 1, 0, 16'h0050, 0, 0, 16'h0, 1, 0, 32'h0);
        expect_ev(0, 0, 32'h0050);
        step(0, 0, 0, 16'h0, 1, 0, 16'h0060, 1, 0, 32'h0);
        expect_ev(0, 1, 32'h0060);
        step(0, 1, 0, 16'h0070, 0, 0, 16'h0, 1, 0, 32'h0);
        check("t4_masked_req", {31'b0, data_req_o}, 0);
        check("t4_masked_addr", {16'b0, data_addr_o}, 0);
        step(0, 1, 0, 16'h0070, 1, 1, 16'h0080, 1, 0, 32'h0);
        expect_ev(0, 1, 32'h0080);
        check("t4_write_wr", {31'b0, data_wr_o}, 1);
        step(0, 1, 0, 16'h0070, 0, 0, 16'h0, 1, 1, 32'hAAAA0001);
        expect_ev(1, 0, 32'hAAAA0001);
        check("t4_full_pop_req", {31'b0, data_req_o}, 0);
        step(0, 1, 0, 16'h0070, 0, 0, 16'h0, 1, 1, 32'hAAAA0002);
        expect_ev(0, 0, 32'h0070);
        expect_ev(1, 1, 32'hAAAA0002);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 32'hAAAA0003);
        expect_ev(1, 0, 32'hAAAA0003);
        idle(0);
        check("t4_err_clear", {31'b0, rsp_err_o}, 0);

        // 5: response with nothing outstanding.
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 32'h0BAD0BAD);
        check("t5_no_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 0);
        idle(0);
        check("t5_err_set", {31'b0, rsp_err_o}, 1);
        idle(0);
        check("t5_err_sticky", {31'b0, rsp_err_o}, 1);

        // 6: reset with one read outstanding; its late response is an error.
        step(0, 1, 0, 16'h0090, 0, 0, 16'h0, 1, 0, 32'h0);
        expect_ev(0, 0, 32'h0090);
        step(1, 1, 0, 16'h0090, 0, 0, 16'h0, 1, 0, 32'h0);
        check("t6_rst_req", {31'b0, data_req_o}, 0);
        check("t6_rst_gnt", {30'b0, m1_gnt_o, m0_gnt_o}, 0);
        idle(0);
        check("t6_err_cleared", {31'b0, rsp_err_o}, 0);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 32'h0057A1E0);
        check("t6_stale_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 0);
        idle(0);
        check("t6_err_set", {31'b0, rsp_err_o}, 1);

        idle(0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
